// File: rtl/cpu_sequencer_if.sv
// Bus between the instruction sequencer and its surrounding datapath/control unit.
interface cpu_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             run;
  logic [7:0]       imem_data;
  logic             dec_two_byte;
  logic             dec_mem_read;
  logic             dec_mem_write;
  logic             dec_reg_write;
  logic [7:0]       imem_addr;
  logic [7:0]       ir;
  logic [7:0]       imm;
  logic             rf_we;
  logic             dmem_we;
  logic             dmem_re;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  // Sequencer side
  modport master (
    input  run, imem_data, dec_two_byte, dec_mem_read, dec_mem_write, dec_reg_write,
    output imem_addr, ir, imm, rf_we, dmem_we, dmem_re, halted, state, retired
  );

  // Datapath / environment side
  modport slave (
    output run, imem_data, dec_two_byte, dec_mem_read, dec_mem_write, dec_reg_write,
    input  imem_addr, ir, imm, rf_we, dmem_we, dmem_re, halted, state, retired
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/fetch2/exec/mem/wb/halt with retire counter.
module cpu_sequencer #(
  parameter logic [7:0]  HALT_OPCODE = 8'hF0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  cpu_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [7:0]       ir_q, ir_d;
  logic [7:0]       imm_q, imm_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic             rf_we_c;
  logic             dmem_we_c;
  logic             dmem_re_c;

  // State and architectural registers; reset wins over every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= 8'd0;
      ir_q      <= 8'd0;
      imm_q     <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, register updates and per-state enables
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    retire_c  = 1'b0;
    rf_we_c   = 1'b0;
    dmem_we_c = 1'b0;
    dmem_re_c = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          ir_d    = bus.imem_data;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == HALT_OPCODE)   state_d = S_HALT;
        else if (bus.dec_two_byte) state_d = S_FETCH2;
        else                       state_d = S_EXEC;
      end
      S_FETCH2: begin
        imm_d   = bus.imem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.dec_mem_read || bus.dec_mem_write) begin
          state_d = S_MEM;
        end else if (bus.dec_reg_write) begin
          state_d = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        // A store takes precedence when both memory decodes are set
        dmem_we_c = bus.dec_mem_write;
        dmem_re_c = bus.dec_mem_read & ~bus.dec_mem_write;
        if (dmem_re_c && bus.dec_reg_write) begin
          state_d = S_WB;
        end else begin
          state_d  = S_FETCH;
          retire_c = 1'b1;
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        state_d  = S_FETCH;
        retire_c = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
  end

  // Outputs
  assign bus.imem_addr = pc_q;
  assign bus.ir        = ir_q;
  assign bus.imm       = imm_q;
  assign bus.rf_we     = rf_we_c;
  assign bus.dmem_we   = dmem_we_c;
  assign bus.dmem_re   = dmem_re_c;
  assign bus.halted    = (state_q == S_HALT);
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small instruction memory and decode model.
module tb_cpu_sequencer;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_STORE = 8'h20;
  localparam logic [7:0] OP_LDST  = 8'h30;
  localparam logic [7:0] OP_HALT  = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] mem [256];
  int         checks = 0;
  int         failures = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data = mem[bus.imem_addr];

  // Control-unit model: decode of ir
  always_comb begin
    bus.dec_two_byte  = 1'b0;
    bus.dec_mem_read  = 1'b0;
    bus.dec_mem_write = 1'b0;
    bus.dec_reg_write = 1'b0;
    case (bus.ir)
      OP_ADD:   bus.dec_reg_write = 1'b1;
      OP_LOAD:  begin bus.dec_two_byte = 1'b1; bus.dec_mem_read = 1'b1; bus.dec_reg_write = 1'b1; end
      OP_STORE: begin bus.dec_two_byte = 1'b1; bus.dec_mem_write = 1'b1; end
      OP_LDST:  begin bus.dec_two_byte = 1'b1; bus.dec_mem_read = 1'b1;
                      bus.dec_mem_write = 1'b1; bus.dec_reg_write = 1'b1; end
      default: ;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = OP_NOP;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = OP_ADD;
    bus.run = 1'b1;
    do_reset();
    checks++; if (bus.state !== 3'd0)    begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    checks++; if (bus.imem_addr !== 8'h00) begin failures++; $display("FAIL reset_pc: got %0h expected 0", bus.imem_addr); end
    checks++; if (bus.ir !== 8'h00 || bus.imm !== 8'h00) begin failures++; $display("FAIL reset_ir_imm: got %0h/%0h expected 0/0", bus.ir, bus.imm); end
    checks++; if (bus.retired !== 16'd0 || bus.halted !== 1'b0) begin failures++; $display("FAIL reset_retired_halted: got %0d/%0b expected 0/0", bus.retired, bus.halted); end
    checks++; if ({bus.rf_we, bus.dmem_we, bus.dmem_re} !== 3'b000) begin failures++; $display("FAIL reset_enables: got %b expected 000", {bus.rf_we, bus.dmem_we, bus.dmem_re}); end
    bus.run = 1'b0;
  endtask

  task automatic test_add();
    int es [4] = '{1, 3, 5, 0};
    logic er [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    clear_mem();
    mem[0] = OP_ADD;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.state !== 3'(es[i])) begin failures++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (bus.rf_we !== er[i]) begin failures++; $display("FAIL add_rf_we[%0d]: got %b expected %b", i, bus.rf_we, er[i]); end
    end
    bus.run = 1'b0;
    checks++; if (bus.retired !== 16'd1) begin failures++; $display("FAIL add_retired: got %0d expected 1", bus.retired); end
    checks++; if (bus.imem_addr !== 8'h01) begin failures++; $display("FAIL add_pc: got %0h expected 1", bus.imem_addr); end
  endtask

  task automatic test_load();
    int es [6] = '{1, 2, 3, 4, 5, 0};
    logic ere [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic erf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_mem();
    mem[0] = OP_LOAD;
    mem[1] = 8'h20;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.state !== 3'(es[i])) begin failures++; $display("FAIL load_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (bus.dmem_re !== ere[i] || bus.dmem_we !== 1'b0) begin failures++; $display("FAIL load_dmem[%0d]: got re=%b we=%b expected re=%b we=0", i, bus.dmem_re, bus.dmem_we, ere[i]); end
      checks++; if (bus.rf_we !== erf[i]) begin failures++; $display("FAIL load_rf_we[%0d]: got %b expected %b", i, bus.rf_we, erf[i]); end
    end
    bus.run = 1'b0;
    checks++; if (bus.imm !== 8'h20) begin failures++; $display("FAIL load_imm: got %0h expected 20", bus.imm); end
    checks++; if (bus.imem_addr !== 8'h02) begin failures++; $display("FAIL load_pc: got %0h expected 2", bus.imem_addr); end
    checks++; if (bus.retired !== 16'd1) begin failures++; $display("FAIL load_retired: got %0d expected 1", bus.retired); end
  endtask

  task automatic test_store_wrap();
    int es [5] = '{1, 2, 3, 4, 0};
    logic ewe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int n = 0;
    clear_mem();
    mem[8'hFF] = OP_STORE;
    mem[8'h00] = 8'h40;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    while (!(bus.state === 3'd0 && bus.imem_addr === 8'hFF) && n < 1000) begin
      step();
      n++;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL wrap_reach_ff: got pc=%0h expected pc=ff within 1000 cycles", bus.imem_addr); end
    checks++; if (bus.retired !== 16'd255) begin failures++; $display("FAIL wrap_retired_pre: got %0d expected 255", bus.retired); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.state !== 3'(es[i])) begin failures++; $display("FAIL store_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (bus.dmem_we !== ewe[i] || bus.rf_we !== 1'b0 || bus.dmem_re !== 1'b0) begin failures++; $display("FAIL store_en[%0d]: got we=%b rf=%b re=%b expected we=%b rf=0 re=0", i, bus.dmem_we, bus.rf_we, bus.dmem_re, ewe[i]); end
    end
    bus.run = 1'b0;
    checks++; if (bus.imm !== 8'h40) begin failures++; $display("FAIL store_imm: got %0h expected 40", bus.imm); end
    checks++; if (bus.imem_addr !== 8'h01) begin failures++; $display("FAIL store_pc: got %0h expected 1", bus.imem_addr); end
    checks++; if (bus.retired !== 16'd256) begin failures++; $display("FAIL store_retired: got %0d expected 256", bus.retired); end
  endtask

  task automatic test_both_mem();
    int es [5] = '{1, 2, 3, 4, 0};
    logic ewe [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    clear_mem();
    mem[0] = OP_LDST;
    mem[1] = 8'h11;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.state !== 3'(es[i])) begin failures++; $display("FAIL both_state[%0d]: got %0d expected %0d", i, bus.state, es[i]); end
      checks++; if (bus.dmem_we !== ewe[i] || bus.dmem_re !== 1'b0 || bus.rf_we !== 1'b0) begin failures++; $display("FAIL both_en[%0d]: got we=%b re=%b rf=%b expected we=%b re=0 rf=0", i, bus.dmem_we, bus.dmem_re, bus.rf_we, ewe[i]); end
    end
    bus.run = 1'b0;
    checks++; if (bus.retired !== 16'd1) begin failures++; $display("FAIL both_retired: got %0d expected 1", bus.retired); end
  endtask

  task automatic test_run_hold();
    clear_mem();
    mem[0] = OP_ADD;
    bus.run = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.state !== 3'd0 || bus.imem_addr !== 8'h00 || bus.ir !== 8'h00) begin failures++; $display("FAIL hold[%0d]: got state=%0d pc=%0h ir=%0h expected 0/0/0", i, bus.state, bus.imem_addr, bus.ir); end
      checks++; if ({bus.rf_we, bus.dmem_we, bus.dmem_re} !== 3'b000) begin failures++; $display("FAIL hold_en[%0d]: got %b expected 000", i, {bus.rf_we, bus.dmem_we, bus.dmem_re}); end
    end
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    checks++; if (bus.state !== 3'd1 || bus.ir !== OP_ADD || bus.imem_addr !== 8'h01) begin failures++; $display("FAIL hold_resume: got state=%0d ir=%0h pc=%0h expected 1/01/1", bus.state, bus.ir, bus.imem_addr); end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = OP_NOP;
    mem[1] = OP_ADD;
    mem[2] = OP_HALT;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++; if (bus.state !== 3'd1 || bus.halted !== 1'b0) begin failures++; $display("FAIL halt_decode: got state=%0d halted=%b expected 1/0", bus.state, bus.halted); end
    step();
    checks++; if (bus.state !== 3'd6 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_enter: got state=%0d halted=%b expected 6/1", bus.state, bus.halted); end
    for (int i = 0; i < 6; i++) begin
      bus.run = i[0];
      step();
      checks++; if (bus.state !== 3'd6 || bus.retired !== 16'd2 || bus.imem_addr !== 8'h03 || bus.ir !== OP_HALT) begin failures++; $display("FAIL halt_frozen[%0d]: got state=%0d ret=%0d pc=%0h ir=%0h expected 6/2/3/f0", i, bus.state, bus.retired, bus.imem_addr, bus.ir); end
      checks++; if ({bus.rf_we, bus.dmem_we, bus.dmem_re} !== 3'b000) begin failures++; $display("FAIL halt_en[%0d]: got %b expected 000", i, {bus.rf_we, bus.dmem_we, bus.dmem_re}); end
    end
    bus.run = 1'b0;
    do_reset();
    checks++; if (bus.imem_addr !== 8'h00 || bus.halted !== 1'b0 || bus.state !== 3'd0) begin failures++; $display("FAIL halt_exit: got pc=%0h halted=%b state=%0d expected 0/0/0", bus.imem_addr, bus.halted, bus.state); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = OP_ADD;
    mem[1] = OP_STORE;
    mem[2] = 8'h55;
    bus.run = 1'b0;
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++; if (bus.state !== 3'd4 || bus.dmem_we !== 1'b1 || bus.retired !== 16'd1) begin failures++; $display("FAIL mid_in_mem: got state=%0d we=%b ret=%0d expected 4/1/1", bus.state, bus.dmem_we, bus.retired); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.run = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.dmem_we !== 1'b0 || bus.retired !== 16'd0) begin failures++; $display("FAIL mid_reset: got state=%0d we=%b ret=%0d expected 0/0/0", bus.state, bus.dmem_we, bus.retired); end
    checks++; if (bus.imem_addr !== 8'h00 || bus.ir !== 8'h00 || bus.imm !== 8'h00) begin failures++; $display("FAIL mid_reset_regs: got pc=%0h ir=%0h imm=%0h expected 0/0/0", bus.imem_addr, bus.ir, bus.imm); end
  endtask

  initial begin
    bus.run = 1'b0;
    clear_mem();
    test_reset();
    test_add();
    test_load();
    test_store_wrap();
    test_both_mem();
    test_run_hold();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
